// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding, parameter defaults and sizing helpers for the SAR ADC controllers
package sar_pkg;
    localparam int SAR_WIDTH_DEF         = 10;
    localparam int SAR_CHANNELS_DEF      = 4;
    localparam int SAR_SAMPLE_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } sar_state_e;

    function automatic int sar_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Register widths never collapse to zero bits.
    function automatic int sar_min1_clog2(input int n);
        return (n > 1) ? sar_clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sar_bit_engine.sv
// sar_bit_engine: successive-approximation mask/result registers, one bit resolved per step
module sar_bit_engine #(
    parameter int Width = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             init_i,
    input  logic             step_i,
    input  logic             cmp_i,
    output logic [Width-1:0] res_o,
    output logic [Width-1:0] dac_o,
    output logic             last_o
);
    logic [Width-1:0] mask_q;
    logic [Width-1:0] res_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q <= '0;
            res_q  <= '0;
        end else if (init_i) begin
            mask_q <= {1'b1, {(Width-1){1'b0}}};
            res_q  <= '0;
        end else if (step_i) begin
            res_q  <= cmp_i ? (res_q | mask_q) : res_q;
            mask_q <= mask_q >> 1;
        end
    end

    assign res_o  = res_q;
    assign last_o = mask_q[0];
    // The DAC only carries a trial code while a conversion is stepping.
    assign dac_o  = step_i ? (res_q | mask_q) : '0;
endmodule

// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: multi-channel SAR ADC scan controller with a valid/ready result stream
module sar_scan_ctrl
    import sar_pkg::*;
#(
    parameter  int Width        = SAR_WIDTH_DEF,
    parameter  int Channels     = SAR_CHANNELS_DEF,
    parameter  int SampleCycles = SAR_SAMPLE_CYCLES_DEF,
    localparam int ChW          = sar_min1_clog2(Channels)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                cont_i,
    input  logic [Channels-1:0] ch_mask_i,
    input  logic                cmp_i,
    output logic                sample_o,
    output logic [ChW-1:0]      ch_sel_o,
    output logic [Width-1:0]    dac_o,
    output logic [Width-1:0]    result_o,
    output logic [ChW-1:0]      result_ch_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                busy_o,
    output logic                scan_done_o
);
    localparam int CntW = sar_min1_clog2(SampleCycles);

    sar_state_e          state_q;
    logic [Channels-1:0] mask_q;
    logic [CntW-1:0]     cnt_q;
    logic [ChW-1:0]      ch_q;
    logic [ChW-1:0]      nxt;
    logic                has_nxt;
    logic                eng_init;
    logic                eng_step;
    logic                eng_last;
    logic [Width-1:0]    eng_res;
    logic                slot_free;

    function automatic logic [ChW-1:0] lowest(input logic [Channels-1:0] m);
        logic [ChW-1:0] r;
        r = '0;
        for (int i = Channels - 1; i >= 0; i--) if (m[i]) r = ChW'(i);
        return r;
    endfunction

    // Priority pick of the nearest enabled channel above the current one.
    always_comb begin
        nxt     = '0;
        has_nxt = 1'b0;
        for (int i = Channels - 1; i >= 0; i--) begin
            if (mask_q[i] && i > int'(ch_q)) begin
                nxt     = ChW'(i);
                has_nxt = 1'b1;
            end
        end
    end

    assign eng_init  = state_q == ST_SAMPLE && cnt_q == '0;
    assign eng_step  = state_q == ST_CONVERT;
    assign slot_free = !valid_o || ready_i;
    assign ch_sel_o  = ch_q;

    sar_bit_engine #(.Width(Width)) u_engine (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .init_i (eng_init),
        .step_i (eng_step),
        .cmp_i  (cmp_i),
        .res_o  (eng_res),
        .dac_o  (dac_o),
        .last_o (eng_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            cnt_q       <= '0;
            ch_q        <= '0;
            sample_o    <= 1'b0;
            result_o    <= '0;
            result_ch_o <= '0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            scan_done_o <= 1'b0;
        end else begin
            scan_done_o <= 1'b0;
            if (valid_o && ready_i) valid_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i && |ch_mask_i) begin
                        mask_q   <= ch_mask_i;
                        ch_q     <= lowest(ch_mask_i);
                        cnt_q    <= CntW'(SampleCycles - 1);
                        sample_o <= 1'b1;
                        busy_o   <= 1'b1;
                        state_q  <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt_q == '0) begin
                        sample_o <= 1'b0;
                        state_q  <= ST_CONVERT;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                ST_CONVERT: begin
                    if (eng_last) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    // A full output slot stalls here so no result is ever overwritten.
                    if (slot_free) begin
                        result_o    <= eng_res;
                        result_ch_o <= ch_q;
                        valid_o     <= 1'b1;
                        if (has_nxt || cont_i) begin
                            ch_q     <= has_nxt ? nxt : lowest(mask_q);
                            cnt_q    <= CntW'(SampleCycles - 1);
                            sample_o <= 1'b1;
                            state_q  <= ST_SAMPLE;
                        end else begin
                            busy_o      <= 1'b0;
                            scan_done_o <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule
